fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with jump/branch redirect and stall,
// plus the IF/ID pipeline register, a capture counter and a sticky misalignment flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_err_q, misalign_err_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        capture;

  always_comb begin
    redirect        = jump | branch_taken;
    // Jump outranks branch, so only the jump target is examined when both fire.
    redirect_target = jump ? jump_target : branch_target;
    pc_plus4        = pc_q + 32'd4;
    capture         = !(flush || redirect) && !stall;

    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_target[31:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end

    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    if (flush || redirect) begin
      if_id_instr_d = NOP_INSTR;
      if_id_pc4_d   = 32'd0;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      if_id_instr_d = i_data;
      if_id_pc4_d   = pc_plus4;
      if_id_valid_d = 1'b1;
    end

    fetch_count_d  = capture ? fetch_count_q + 32'd1 : fetch_count_q;
    misalign_err_d = misalign_err_q | (redirect & (redirect_target[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      if_id_instr_q  <= NOP_INSTR;
      if_id_pc4_q    <= 32'd0;
      if_id_valid_q  <= 1'b0;
      fetch_count_q  <= 32'd0;
      misalign_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_pc4_q    <= if_id_pc4_d;
      if_id_valid_q  <= if_id_valid_d;
      fetch_count_q  <= fetch_count_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign i_addr       = pc_q;
  assign pc           = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc4    = if_id_pc4_q;
  assign if_id_valid  = if_id_valid_q;
  assign fetch_count  = fetch_count_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-edge vectors with expected
// outputs, followed by a hand-written sticky-misalignment sequence.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] i_addr, i_data, pc;
  logic [31:0] if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, misalign_err;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] MEM_TAG = 32'h1000_0000;

  // Instruction memory model: the word at address A is MEM_TAG + A.
  assign i_data = MEM_TAG + i_addr;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .i_addr(i_addr), .i_data(i_data), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .misalign_err(misalign_err)
  );

  typedef struct {
    logic        rst_n, stall, flush, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  task automatic add_vec(input logic r, input logic s, input logic f,
                         input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_pc4, input logic e_valid,
                         input logic [31:0] e_cnt, input logic e_mis);
    vec_t v;
    v.rst_n = r; v.stall = s; v.flush = f; v.br = b; v.bt = bt; v.jp = j; v.jt = jt;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.e_cnt = e_cnt; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    @(negedge clk);
    rst_n = r; stall = s; flush = f; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; branch_target = 32'd0; jump_target = 32'd0;

    //      rst s f br bt            jp jt            pc            instr         pc4           v  cnt mis
    add_vec(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h1000_0000,32'h4,        1, 1, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h1000_0004,32'h8,        1, 2, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'h1000_0008,32'hC,        1, 3, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'h1000_000C,32'h10,       1, 4, 0);
    add_vec(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h1000_0000,32'h4,        1, 1, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h1000_0004,32'h8,        1, 2, 0);
    // stall at pc=8 for two cycles, then release
    add_vec(1, 1, 0, 0, 32'hDEAD_BEE3,0, 32'hDEAD_BEE1,32'h8,        32'h1000_0004,32'h8,        1, 2, 0);
    add_vec(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h1000_0004,32'h8,        1, 2, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'h1000_0008,32'hC,        1, 3, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'h1000_000C,32'h10,       1, 4, 0);
    // jump beats branch
    add_vec(1, 0, 0, 1, 32'h40,       1, 32'h80,       32'h80,       NOP,          32'h0,        0, 4, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       32'h1000_0080,32'h84,       1, 5, 0);
    // misaligned branch target ignored because jump is selected
    add_vec(1, 0, 0, 1, 32'h43,       1, 32'h100,      32'h100,      NOP,          32'h0,        0, 5, 0);
    // branch redirects even while stalled
    add_vec(1, 1, 0, 1, 32'h200,      0, 32'h0,        32'h200,      NOP,          32'h0,        0, 5, 0);
    // flush alone bubbles IF/ID, pc still advances
    add_vec(1, 0, 1, 0, 32'h0,        0, 32'h0,        32'h204,      NOP,          32'h0,        0, 5, 0);
    add_vec(1, 0, 0, 0, 32'h0,        1, 32'h106,      32'h104,      NOP,          32'h0,        0, 5, 1);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h108,      32'h1000_0104,32'h108,      1, 6, 1);
    // wrap at top of address space
    add_vec(1, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,32'hFFFF_FFFC,NOP,          32'h0,        0, 6, 1);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0FFF_FFFC,32'h0,        1, 7, 1);
    add_vec(1, 1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          32'h0,        0, 7, 1);
    // reset overrides stall and branch
    add_vec(0, 1, 0, 1, 32'h300,      0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0, 0);
    add_vec(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h1000_0000,32'h4,        1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].bt,
            vecs[i].jp, vecs[i].jt);
      check32("pc",           i, pc,                  vecs[i].e_pc);
      check32("i_addr",       i, i_addr,              vecs[i].e_pc);
      check32("if_id_instr",  i, if_id_instr,         vecs[i].e_instr);
      check32("if_id_pc4",    i, if_id_pc4,           vecs[i].e_pc4);
      check32("if_id_valid",  i, {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
      check32("fetch_count",  i, fetch_count,         vecs[i].e_cnt);
      check32("misalign_err", i, {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
    end

    // Sticky misalignment: set by a jump, held over 10 normal cycles, cleared by reset.
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    drive(1, 0, 0, 0, 32'h0, 1, 32'h0000_0106);
    check32("seq_jump_pc",  100, pc, 32'h0000_0104);
    check32("seq_jump_mis", 100, {31'd0, misalign_err}, 32'd1);
    for (int k = 1; k <= 10; k++) exp_q.push_back(32'h0000_0104 + 32'(4 * k));
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] exp_pc;
      drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
      exp_pc = exp_q.pop_front();
      check32("seq_pc",  100 + k, pc, exp_pc);
      check32("seq_mis", 100 + k, {31'd0, misalign_err}, 32'd1);
    end
    check32("seq_count", 111, fetch_count, 32'd10);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    check32("seq_rst_mis", 112, {31'd0, misalign_err}, 32'd0);
    check32("seq_rst_cnt", 112, fetch_count, 32'd0);
    check32("seq_rst_pc",  112, pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
